scanchain_mc_writer: RTL and testbench

SCANCHAIN_MC_WRITER -- requirements
Module: scanchain_mc_writer

---
 rtl/scanchain_pkg.sv | 21 ++
 rtl/scan_phase_timer.sv | 22 ++
 rtl/scanchain_mc_writer.sv | 122 ++++++++++++
 tb/tb_scanchain_mc_writer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/scanchain_pkg.sv
// scanchain_pkg: command-mode encodings and FSM state enumeration shared by the scan-chain writer.
package scanchain_pkg;

    typedef enum logic [1:0] {
        MODE_WRITE       = 2'd0,
        MODE_WRITE_READ  = 2'd1,
        MODE_CHAIN_RESET = 2'd2,
        MODE_RSVD        = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_LATCH_LO,
        ST_LATCH_HI,
        ST_RESP,
        ST_CHRST
    } state_e;

endpackage

// File: rtl/scan_phase_timer.sv
// scan_phase_timer: loadable down-counter that pulses phase_done_o once every period_i cycles.
module scan_phase_timer #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] period_i,
    output logic         phase_done_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign phase_done_o = (cnt_q == '0);
    assign cnt_d        = (load_i || phase_done_o) ? period_i - W'(1) : cnt_q - W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/scanchain_mc_writer.sv
// scanchain_mc_writer: serialises {addr, payload} frames onto one of several scan chains,
// optionally capturing scan_out, and issues per-chain reset pulses.
module scanchain_mc_writer
    import scanchain_pkg::*;
#(
    parameter int  NUM_CHAINS   = 4,
    parameter int  ADDR_BITS    = 12,
    parameter int  PAYLOAD_BITS = 169,
    parameter int  DIV_BITS     = 17,
    localparam int FRAME_BITS   = ADDR_BITS + PAYLOAD_BITS,
    localparam int CW           = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_mode,
    input  logic [CW-1:0]           cmd_chain,
    input  logic [ADDR_BITS-1:0]    cmd_addr,
    input  logic [PAYLOAD_BITS-1:0] cmd_payload,
    input  logic [DIV_BITS-1:0]     half_div,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [CW-1:0]           rsp_chain,
    output logic [FRAME_BITS-1:0]   rsp_data,
    output logic                    cmd_err,
    output logic                    busy,
    output logic [NUM_CHAINS-1:0]   scan_clk,
    output logic [NUM_CHAINS-1:0]   scan_en,
    output logic [NUM_CHAINS-1:0]   scan_in,
    output logic [NUM_CHAINS-1:0]   scan_reset,
    input  logic [NUM_CHAINS-1:0]   scan_out
);

    localparam int BW = $clog2(FRAME_BITS + 1);

    state_e                  state_q, state_d;
    mode_e                   mode_q;
    logic [CW-1:0]           chain_q;
    logic [FRAME_BITS-1:0]   frame_q, cap_q;
    logic [DIV_BITS-1:0]     div_q, div_eff;
    logic [BW-1:0]           bit_q;
    logic                    err_q, alive_q;
    logic                    accept, cmd_ok, start, phase_done, sh_step, last_bit, shifting;
    logic [NUM_CHAINS-1:0]   sel;

    assign accept   = cmd_valid && cmd_ready;
    assign cmd_ok   = (int'(cmd_chain) < NUM_CHAINS) && (cmd_mode != MODE_RSVD);
    assign start    = accept && cmd_ok;
    assign div_eff  = (half_div == '0) ? DIV_BITS'(1) : half_div;
    assign sh_step  = phase_done && (state_q == ST_SHIFT_HI);
    assign last_bit = (bit_q == BW'(FRAME_BITS - 1));

    // The timer restarts on acceptance so every phase is aligned to the command.
    scan_phase_timer #(.W(DIV_BITS)) u_timer (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_i       (start),
        .period_i     (start ? div_eff : div_q),
        .phase_done_o (phase_done)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (start) state_d = (cmd_mode == MODE_CHAIN_RESET) ? ST_CHRST : ST_SHIFT_LO;
            ST_SHIFT_LO: if (phase_done) state_d = ST_SHIFT_HI;
            ST_SHIFT_HI: if (phase_done) state_d = last_bit ? ST_LATCH_LO : ST_SHIFT_LO;
            ST_LATCH_LO: if (phase_done) state_d = ST_LATCH_HI;
            ST_LATCH_HI: if (phase_done) state_d = (mode_q == MODE_WRITE_READ) ? ST_RESP : ST_IDLE;
            ST_RESP:     if (rsp_ready) state_d = ST_IDLE;
            ST_CHRST:    if (phase_done && bit_q[0]) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_WRITE;
            chain_q <= '0;
            frame_q <= '0;
            cap_q   <= '0;
            div_q   <= DIV_BITS'(1);
            bit_q   <= '0;
            err_q   <= 1'b0;
            alive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            alive_q <= 1'b1;
            err_q   <= accept && !cmd_ok;
            if (start) begin
                mode_q  <= mode_e'(cmd_mode);
                chain_q <= cmd_chain;
                frame_q <= {cmd_addr, cmd_payload};
                div_q   <= div_eff;
                bit_q   <= '0;
            end else if (sh_step) begin
                frame_q <= frame_q << 1;
                bit_q   <= bit_q + BW'(1);
                if (mode_q == MODE_WRITE_READ) cap_q <= {cap_q[FRAME_BITS-2:0], scan_out[chain_q]};
            end else if (phase_done && state_q == ST_CHRST) begin
                bit_q <= bit_q + BW'(1);
            end
        end
    end

    assign shifting   = (state_q == ST_SHIFT_LO) || (state_q == ST_SHIFT_HI);
    assign sel        = NUM_CHAINS'(1) << chain_q;
    assign scan_clk   = sel & {NUM_CHAINS{(state_q == ST_SHIFT_HI) || (state_q == ST_LATCH_HI)}};
    assign scan_en    = sel & {NUM_CHAINS{shifting}};
    assign scan_in    = sel & {NUM_CHAINS{shifting && frame_q[FRAME_BITS-1]}};
    assign scan_reset = sel & {NUM_CHAINS{state_q == ST_CHRST}};

    assign cmd_ready = alive_q && (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_chain = chain_q;
    assign rsp_data  = cap_q;
    assign cmd_err   = err_q;

endmodule

// File: tb/tb_scanchain_mc_writer.sv
// tb_scanchain_mc_writer: directed checks of the scan-chain writer with 4 chains and a 12-bit frame.
module tb_scanchain_mc_writer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_mode = '0;
    logic [1:0]  cmd_chain = '0;
    logic [3:0]  cmd_addr = '0;
    logic [7:0]  cmd_payload = '0;
    logic [16:0] half_div = 17'd2;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_chain;
    logic [11:0] rsp_data;
    logic        cmd_err, busy;
    logic [3:0]  scan_clk, scan_en, scan_in, scan_reset, scan_out;

    int tests, fails;

    always #5 clk = ~clk;

    scanchain_mc_writer #(.NUM_CHAINS(4), .ADDR_BITS(4), .PAYLOAD_BITS(8), .DIV_BITS(17)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_chain(cmd_chain),
        .cmd_addr(cmd_addr), .cmd_payload(cmd_payload), .half_div(half_div),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_chain(rsp_chain), .rsp_data(rsp_data),
        .cmd_err(cmd_err), .busy(busy),
        .scan_clk(scan_clk), .scan_en(scan_en), .scan_in(scan_in), .scan_reset(scan_reset),
        .scan_out(scan_out)
    );

    // Chain-1 model: captures scan_in/scan_en at the rising scan_clk, shifts on the falling one.
    logic [11:0] chain_m = '0;
    logic        preload = 1'b0;
    logic        prev1 = 1'b0, en_l = 1'b0, in_l = 1'b0;
    assign scan_out = {2'b00, chain_m[11], 1'b0};

    always @(posedge clk) begin
        prev1 <= scan_clk[1];
        if (preload) chain_m <= 12'hF0F;
        else begin
            if (scan_clk[1] && !prev1) begin
                en_l <= scan_en[1];
                in_l <= scan_in[1];
            end
            if (!scan_clk[1] && prev1 && en_l) chain_m <= {chain_m[10:0], in_l};
        end
    end

    int         sh_cnt [4], lt_cnt [4], rs_cnt [4], act_cnt [4];
    bit  [31:0] sh_bits [4];
    logic [3:0] prev_sc = '0;

    always @(negedge clk) begin
        for (int c = 0; c < 4; c++) begin
            if (scan_clk[c] && !prev_sc[c]) begin
                if (scan_en[c]) begin
                    sh_cnt[c]  <= sh_cnt[c] + 1;
                    sh_bits[c] <= {sh_bits[c][30:0], scan_in[c]};
                end else lt_cnt[c] <= lt_cnt[c] + 1;
            end
            if (scan_reset[c]) rs_cnt[c] <= rs_cnt[c] + 1;
            if (scan_clk[c] | scan_en[c] | scan_in[c] | scan_reset[c]) act_cnt[c] <= act_cnt[c] + 1;
        end
        prev_sc <= scan_clk;
    end

    int b_sh [4], b_lt [4], b_rs [4], b_act [4];

    task automatic snap();
        for (int c = 0; c < 4; c++) begin
            b_sh[c]  = sh_cnt[c];
            b_lt[c]  = lt_cnt[c];
            b_rs[c]  = rs_cnt[c];
            b_act[c] = act_cnt[c];
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] m, input logic [1:0] ch, input logic [3:0] a, input logic [7:0] p);
        cmd_mode    = m;
        cmd_chain   = ch;
        cmd_addr    = a;
        cmd_payload = p;
        cmd_valid   = 1'b1;
        @(posedge clk); #1;
        cmd_valid   = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!cmd_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    int  n;
    logic stable;

    initial begin
        tests = 0;
        fails = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_scan", {scan_clk, scan_en, scan_in, scan_reset}, 0);
        chk("rst_rsp", {rsp_valid, rsp_data}, 0);
        chk("rst_err", cmd_err, 0);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", cmd_ready, 1);

        // WRITE chain 2; half_div changed after acceptance must be ignored
        snap();
        send(2'd0, 2'd2, 4'hA, 8'h5C);
        half_div = 17'd5;
        chk("wr_busy", busy, 1);
        wait_ready(n);
        half_div = 17'd2;
        chk("wr_cycles", n, 52);
        chk("wr_bits", sh_bits[2][11:0], 12'hA5C);
        chk("wr_shifts", sh_cnt[2] - b_sh[2], 12);
        chk("wr_latch", lt_cnt[2] - b_lt[2], 1);
        chk("wr_other", (act_cnt[0] - b_act[0]) + (act_cnt[1] - b_act[1]) + (act_cnt[3] - b_act[3]), 0);

        // WRITE_READ chain 1 against the looped model
        preload = 1'b1;
        @(posedge clk); #1;
        preload = 1'b0;
        chk("model_pre", chain_m, 12'hF0F);
        send(2'd1, 2'd1, 4'h3, 8'h96);
        n = 0;
        while (!rsp_valid && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wrd_cycles", n, 52);
        chk("wrd_data", rsp_data, 12'hF0F);
        chk("wrd_chain", rsp_chain, 1);
        chk("wrd_model", chain_m, 12'h396);
        chk("wrd_ready_low", cmd_ready, 0);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            stable &= rsp_valid && (rsp_data == 12'hF0F) && (rsp_chain == 2'd1);
        end
        chk("rsp_stall", stable, 1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_done_valid", rsp_valid, 0);
        chk("rsp_done_ready", cmd_ready, 1);

        // reserved mode is rejected with a one-cycle error
        snap();
        cmd_mode  = 2'd3;
        cmd_chain = 2'd3;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("err_pulse", cmd_err, 1);
        chk("err_ready", cmd_ready, 1);
        chk("err_busy", busy, 0);
        @(posedge clk); #1;
        chk("err_clear", cmd_err, 0);
        chk("err_noact", (act_cnt[0] - b_act[0]) + (act_cnt[1] - b_act[1]) + (act_cnt[2] - b_act[2]) + (act_cnt[3] - b_act[3]), 0);

        // CHAIN_RESET chain 0
        snap();
        send(2'd2, 2'd0, 4'h0, 8'h00);
        wait_ready(n);
        chk("chrst_cycles", n, 4);
        chk("chrst_len", rs_cnt[0] - b_rs[0], 4);
        chk("chrst_noclk", (sh_cnt[0] - b_sh[0]) + (lt_cnt[0] - b_lt[0]), 0);

        // reset mid-shift
        snap();
        send(2'd0, 2'd2, 4'hF, 8'hFF);
        n = 0;
        while ((sh_cnt[2] - b_sh[2]) < 6 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("mid_reached", sh_cnt[2] - b_sh[2], 6);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_scan", {scan_clk, scan_en, scan_in, scan_reset}, 0);
        chk("mid_busy", busy, 0);
        chk("mid_ready", cmd_ready, 0);
        chk("mid_rsp", {rsp_valid, rsp_data}, 0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_ready", cmd_ready, 1);
        chk("post_idle", {busy, scan_en, scan_clk}, 0);
        snap();
        send(2'd0, 2'd3, 4'h1, 8'hE7);
        wait_ready(n);
        chk("post_cycles", n, 52);
        chk("post_bits", sh_bits[3][11:0], 12'h1E7);
        chk("post_latch", lt_cnt[3] - b_lt[3], 1);

        // half_div = 0 behaves as 1
        half_div = 17'd0;
        snap();
        send(2'd0, 2'd0, 4'h6, 8'h3C);
        wait_ready(n);
        chk("div0_cycles", n, 26);
        chk("div0_bits", sh_bits[0][11:0], 12'h63C);
        chk("div0_shifts", sh_cnt[0] - b_sh[0], 12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
